// File: rtl/sm_rom_arbiter_pkg.sv
// Shared parameters and helpers for the instruction-ROM arbiter slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sm_rom_arbiter_pkg;

    localparam int N_CORES_DEF = 4;
    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;

    // Pointer width; a single-core build still needs one bit of pointer.
    function automatic int calc_ptr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int PTR_W_DEF = calc_ptr_w(N_CORES_DEF);

endpackage

// File: rtl/sm_rom_arbiter_if.sv
// Fetch-port bundle between the cores, the arbiter and the shared ROM.
// Latency: n/a (wiring only).
// Backpressure: req is held by a core until its gnt; en freezes all grants.
interface sm_rom_arbiter_if
    import sm_rom_arbiter_pkg::*;
#(
    parameter int N_CORES = N_CORES_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
);
    logic                      en;
    logic [N_CORES-1:0]        req;
    logic [N_CORES*ADDR_W-1:0] addr;
    logic [N_CORES-1:0]        gnt;
    logic [N_CORES-1:0]        rvalid;
    logic [DATA_W-1:0]         rdata;
    logic [ADDR_W-1:0]         rom_a;
    logic [DATA_W-1:0]         rom_rd;

    // Cores plus ROM side: drive requests and ROM data, observe results.
    modport master (
        output en, req, addr, rom_rd,
        input  gnt, rvalid, rdata, rom_a
    );

    // Arbiter side.
    modport slave (
        input  en, req, addr, rom_rd,
        output gnt, rvalid, rdata, rom_a
    );
endinterface

// File: rtl/sm_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping.
// Latency: zero cycles (purely combinational).
// Backpressure: none; caller decides whether the pick becomes a grant.
module sm_rr_pick
    import sm_rom_arbiter_pkg::*;
#(
    parameter int N     = N_CORES_DEF,
    parameter int PTR_W = calc_ptr_w(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [PTR_W-1:0] o_idx,
    output logic             o_any
);

    int w_j;

    // Scan ptr+1, ptr+2, ... modulo N; the first set request wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = 0;
        for (int k = 1; k <= N; k++) begin
            w_j = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[w_j]) begin
                o_any      = 1'b1;
                o_idx      = PTR_W'(w_j);
                o_gnt[w_j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sm_rom_arbiter.sv
// Round-robin sharing of one combinational-read instruction ROM among cores.
// Latency: grant same cycle as req; rvalid/rdata registered one cycle later.
// Backpressure: losers keep req high; en=0 freezes grants and the pointer.
module sm_rom_arbiter
    import sm_rom_arbiter_pkg::*;
#(
    parameter int N_CORES = N_CORES_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    sm_rom_arbiter_if.slave  bus
);

    localparam int PTR_W = calc_ptr_w(N_CORES);

    logic [PTR_W-1:0]   r_ptr;
    logic [N_CORES-1:0] r_rvalid;
    logic [DATA_W-1:0]  r_rdata;

    logic [N_CORES-1:0] w_pick_gnt;
    logic [PTR_W-1:0]   w_idx;
    logic               w_pick_any;
    logic               w_any;
    logic [ADDR_W-1:0]  w_rom_a;

    sm_rr_pick #(
        .N     (N_CORES),
        .PTR_W (PTR_W)
    ) u_pick (
        .i_req (bus.req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_idx),
        .o_any (w_pick_any)
    );

    // A grant exists only out of reset, with arbitration enabled and a request present.
    assign w_any = rst_n & bus.en & w_pick_any;

    // Route the winner's address to the ROM; zero otherwise so idle slices never leak.
    always_comb begin
        w_rom_a = '0;
        if (w_any) begin
            w_rom_a = bus.addr[int'(w_idx)*ADDR_W +: ADDR_W];
        end
    end

    assign bus.gnt    = w_any ? w_pick_gnt : '0;
    assign bus.rom_a  = w_rom_a;
    assign bus.rvalid = r_rvalid;
    assign bus.rdata  = r_rdata;

    // Register the ROM word and advance the pointer on every grant; idle cycles keep data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= PTR_W'(N_CORES - 1);
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else if (w_any) begin
            r_ptr    <= w_idx;
            r_rvalid <= w_pick_gnt;
            r_rdata  <= bus.rom_rd;
        end else begin
            r_rvalid <= '0;
        end
    end

endmodule

// File: tb/tb_sm_rom_arbiter.sv
// Directed bench for sm_rom_arbiter with a behavioural ROM.
// Latency: checks combinational gnt at #1 after input change, registered outputs #1 after posedge.
// Backpressure: exercises en freeze and held/dropped requests.
module tb_sm_rom_arbiter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    sm_rom_arbiter_if bus ();

    sm_rom_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Behavioural ROM: a tag plus the low address bits.
    assign bus.rom_rd = {16'hC0DE, bus.rom_a[15:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int core, input logic [31:0] a);
        bus.addr[core*32 +: 32] = a;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        bus.en   = 1'b1;
        bus.req  = 4'b1111;
        for (int i = 0; i < 4; i++) set_addr(i, 32'(i + 16));

        // Reset held with all cores requesting.
        #2;
        chk("rst_gnt",    64'(bus.gnt),    64'h0);
        chk("rst_rom_a",  64'(bus.rom_a),  64'h0);
        chk("rst_rvalid", 64'(bus.rvalid), 64'h0);
        chk("rst_rdata",  64'(bus.rdata),  64'h0);
        cyc();
        cyc();
        chk("rst_gnt_hold",    64'(bus.gnt),    64'h0);
        chk("rst_rvalid_hold", 64'(bus.rvalid), 64'h0);

        // Release: core 0 first, then full-contention rotation.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_gnt",   64'(bus.gnt),   64'h1);
        chk("rel_rom_a", 64'(bus.rom_a), 64'h10);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk("rot_gnt",    64'(bus.gnt),    64'(4'b0001 << (k % 4)));
            chk("rot_rvalid", 64'(bus.rvalid), 64'(4'b0001 << ((k - 1) % 4)));
            chk("rot_rdata",  64'(bus.rdata),  64'(32'hC0DE0010 + 32'((k - 1) % 4)));
        end

        // Skip and wrap: ptr=3, req=1010 -> core 1.
        bus.req = 4'b1010;
        #1;
        chk("skip_gnt",   64'(bus.gnt),   64'h2);
        chk("skip_rom_a", 64'(bus.rom_a), 64'h11);
        cyc();
        chk("skip_rvalid", 64'(bus.rvalid), 64'h2);
        chk("skip_rdata",  64'(bus.rdata),  64'hC0DE0011);
        bus.req = 4'b1001;
        #1;
        chk("wrap_gnt3",  64'(bus.gnt),   64'h8);
        chk("wrap_rom_a", 64'(bus.rom_a), 64'h13);
        cyc();
        chk("wrap_rvalid3", 64'(bus.rvalid), 64'h8);
        chk("wrap_rdata3",  64'(bus.rdata),  64'hC0DE0013);
        chk("wrap_gnt0",    64'(bus.gnt),    64'h1);
        cyc();
        chk("wrap_rvalid0", 64'(bus.rvalid), 64'h1);
        chk("wrap_rdata0",  64'(bus.rdata),  64'hC0DE0010);

        // Single requester, back-to-back grants.
        bus.req = 4'b0100;
        set_addr(2, 32'd5);
        #1;
        chk("single_gnt0",  64'(bus.gnt),   64'h4);
        chk("single_rom_a", 64'(bus.rom_a), 64'h5);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("single_gnt",    64'(bus.gnt),    64'h4);
            chk("single_rvalid", 64'(bus.rvalid), 64'h4);
            chk("single_rdata",  64'(bus.rdata),  64'hC0DE0005);
        end

        // en gating with ptr=2 and req=0011.
        bus.en  = 1'b0;
        bus.req = 4'b0011;
        #1;
        chk("en_gnt",         64'(bus.gnt),    64'h0);
        chk("en_rom_a",       64'(bus.rom_a),  64'h0);
        chk("en_prior_valid", 64'(bus.rvalid), 64'h4);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("en_off_gnt",    64'(bus.gnt),    64'h0);
            chk("en_off_rvalid", 64'(bus.rvalid), 64'h0);
            chk("en_off_rdata",  64'(bus.rdata),  64'hC0DE0005);
        end
        bus.en = 1'b1;
        #1;
        chk("en_resume_gnt",   64'(bus.gnt),   64'h1);
        chk("en_resume_rom_a", 64'(bus.rom_a), 64'h10);
        cyc();
        chk("en_resume_rvalid", 64'(bus.rvalid), 64'h1);
        chk("en_resume_rdata",  64'(bus.rdata),  64'hC0DE0010);
        chk("en_next_gnt",      64'(bus.gnt),    64'h2);

        // Asynchronous reset while a response is presented.
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rvalid", 64'(bus.rvalid), 64'h0);
        chk("arst_rdata",  64'(bus.rdata),  64'h0);
        chk("arst_gnt",    64'(bus.gnt),    64'h0);
        chk("arst_rom_a",  64'(bus.rom_a),  64'h0);
        bus.req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_rel_gnt", 64'(bus.gnt), 64'h1);
        cyc();
        chk("arst_rel_rvalid", 64'(bus.rvalid), 64'h1);
        chk("arst_rel_rdata",  64'(bus.rdata),  64'hC0DE0010);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
